// File: rtl/qam_demap.sv
// qam_demap: hard-decision QAM demapper with a two-stage valid/ready pipeline.
//
// Ports:
//   dclk, rst          sample clock, synchronous active-high reset
//   en                 global enable; low freezes all state and deasserts s_ready
//   modi               per-sample mode (0 BPSK .. 6 4096-QAM, 7 idle/discard)
//   s_valid/s_ready    input handshake for inphase/quadrature (12-bit unsigned)
//   m_valid/m_ready    output handshake for data/err_i/err_q
//   data               decoded bits: dI in [5:0], dQ in [11:6]
//   err_i, err_q       signed 13-bit slicing residuals
//   sym_count          delivered symbols, saturating
//   sat_count          delivered symbols with a saturated axis, saturating
module qam_demap (
  input  logic        dclk,
  input  logic        rst,
  input  logic        en,
  input  logic [2:0]  modi,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [11:0] inphase,
  input  logic [11:0] quadrature,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [11:0] data,
  output logic [12:0] err_i,
  output logic [12:0] err_q,
  output logic [15:0] sym_count,
  output logic [15:0] sat_count
);

  localparam logic [2:0] ModeBpsk = 3'd0;
  localparam logic [2:0] ModeIdle = 3'd7;

  // Bits per axis; BPSK slices the I axis with one bit.
  function automatic logic [3:0] bits_of(input logic [2:0] mode);
    return (mode == ModeBpsk) ? 4'd1 : {1'b0, mode};
  endfunction

  // Slice one axis from its pre-rounded sum. Returns {sat, d[5:0], err[12:0]}.
  function automatic logic [19:0] slice_axis(input logic [12:0] sum, input logic [11:0] x,
                                             input logic [3:0] k);
    logic [3:0]  sh;
    logic [12:0] d_raw;
    logic [12:0] d_max;
    logic        sat;
    logic [12:0] d;
    logic [12:0] lvl;
    logic [12:0] err;
    sh    = 4'd12 - k;
    d_raw = sum >> sh;
    d_max = (13'd1 << k) - 13'd1;
    sat   = d_raw > d_max;
    d     = sat ? d_max : d_raw;
    lvl   = d << sh;
    err   = {1'b0, x} - lvl;
    return {sat, d[5:0], err};
  endfunction

  // Stage 1 state
  logic        s1_valid_q, s1_valid_d;
  logic [2:0]  s1_mode_q, s1_mode_d;
  logic [11:0] s1_smp_i_q, s1_smp_i_d;
  logic [11:0] s1_smp_q_q, s1_smp_q_d;
  logic [12:0] s1_sum_i_q, s1_sum_i_d;
  logic [12:0] s1_sum_q_q, s1_sum_q_d;

  // Stage 2 / output state
  logic        m_valid_q, m_valid_d;
  logic [11:0] data_q, data_d;
  logic [12:0] err_i_q, err_i_d;
  logic [12:0] err_q_q, err_q_d;
  logic        sat_q, sat_d;
  logic [15:0] sym_cnt_q, sym_cnt_d;
  logic [15:0] sat_cnt_q, sat_cnt_d;

  logic        advance;
  logic        out_xfer;
  logic [3:0]  k_in;
  logic [12:0] half_in;
  logic [3:0]  k_s1;
  logic [19:0] axis_i;
  logic [19:0] axis_q;

  always_comb begin
    advance  = en && (!m_valid_q || m_ready);
    out_xfer = en && m_valid_q && m_ready;

    // Stage 1: rounding offset for the incoming sample's own mode.
    k_in       = bits_of(modi);
    half_in    = 13'd1 << (4'd11 - k_in);
    s1_valid_d = s1_valid_q;
    s1_mode_d  = s1_mode_q;
    s1_smp_i_d = s1_smp_i_q;
    s1_smp_q_d = s1_smp_q_q;
    s1_sum_i_d = s1_sum_i_q;
    s1_sum_q_d = s1_sum_q_q;
    if (advance) begin
      s1_valid_d = s_valid;
      s1_mode_d  = modi;
      s1_smp_i_d = inphase;
      s1_smp_q_d = quadrature;
      s1_sum_i_d = {1'b0, inphase} + half_in;
      s1_sum_q_d = {1'b0, quadrature} + half_in;
    end

    // Stage 2: slice with the mode carried alongside the sample.
    k_s1   = bits_of(s1_mode_q);
    axis_i = slice_axis(s1_sum_i_q, s1_smp_i_q, k_s1);
    axis_q = slice_axis(s1_sum_q_q, s1_smp_q_q, k_s1);

    m_valid_d = m_valid_q;
    data_d    = data_q;
    err_i_d   = err_i_q;
    err_q_d   = err_q_q;
    sat_d     = sat_q;
    if (advance) begin
      // Idle-mode slots are discarded here and become bubbles.
      m_valid_d = s1_valid_q && (s1_mode_q != ModeIdle);
      err_i_d   = axis_i[12:0];
      if (s1_mode_q == ModeBpsk) begin
        data_d  = {6'd0, axis_i[18:13]};
        err_q_d = 13'd0;
        sat_d   = axis_i[19];
      end else begin
        data_d  = {axis_q[18:13], axis_i[18:13]};
        err_q_d = axis_q[12:0];
        sat_d   = axis_i[19] || axis_q[19];
      end
    end

    sym_cnt_d = sym_cnt_q;
    sat_cnt_d = sat_cnt_q;
    if (out_xfer) begin
      if (sym_cnt_q != 16'hFFFF) sym_cnt_d = sym_cnt_q + 16'd1;
      if (sat_q && (sat_cnt_q != 16'hFFFF)) sat_cnt_d = sat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge dclk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= 3'd0;
      s1_smp_i_q <= 12'd0;
      s1_smp_q_q <= 12'd0;
      s1_sum_i_q <= 13'd0;
      s1_sum_q_q <= 13'd0;
      m_valid_q  <= 1'b0;
      data_q     <= 12'd0;
      err_i_q    <= 13'd0;
      err_q_q    <= 13'd0;
      sat_q      <= 1'b0;
      sym_cnt_q  <= 16'd0;
      sat_cnt_q  <= 16'd0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mode_q  <= s1_mode_d;
      s1_smp_i_q <= s1_smp_i_d;
      s1_smp_q_q <= s1_smp_q_d;
      s1_sum_i_q <= s1_sum_i_d;
      s1_sum_q_q <= s1_sum_q_d;
      m_valid_q  <= m_valid_d;
      data_q     <= data_d;
      err_i_q    <= err_i_d;
      err_q_q    <= err_q_d;
      sat_q      <= sat_d;
      sym_cnt_q  <= sym_cnt_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end

  assign s_ready   = advance;
  assign m_valid   = m_valid_q;
  assign data      = data_q;
  assign err_i     = err_i_q;
  assign err_q     = err_q_q;
  assign sym_count = sym_cnt_q;
  assign sat_count = sat_cnt_q;

endmodule

// File: tb/tb_qam_demap.sv
// tb_qam_demap: directed + randomized bench for qam_demap with an arithmetic
// reference model and an in-order expected-symbol queue.
module tb_qam_demap;

  logic        dclk = 1'b0;
  logic        rst;
  logic        en;
  logic [2:0]  modi;
  logic        s_valid;
  logic        s_ready;
  logic [11:0] inphase;
  logic [11:0] quadrature;
  logic        m_valid;
  logic        m_ready;
  logic [11:0] data;
  logic [12:0] err_i;
  logic [12:0] err_q;
  logic [15:0] sym_count;
  logic [15:0] sat_count;

  qam_demap dut (
    .dclk       (dclk),
    .rst        (rst),
    .en         (en),
    .modi       (modi),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .inphase    (inphase),
    .quadrature (quadrature),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .data       (data),
    .err_i      (err_i),
    .err_q      (err_q),
    .sym_count  (sym_count),
    .sat_count  (sat_count)
  );

  always #5 dclk = ~dclk;

  typedef struct {
    logic [11:0] dat;
    logic [12:0] ei;
    logic [12:0] eq;
    logic        sat;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          sym_exp = 0;
  int          sat_exp = 0;
  bit          hold_chk = 0;
  logic        h_mv;
  logic [11:0] h_data;
  logic [12:0] h_ei;
  logic [12:0] h_eq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Nearest level by integer division, clamped to the top level.
  function automatic exp_t ref_sym(input int m, input int xi, input int xq);
    exp_t r;
    int k, step, maxd, di, dq, ei, eq;
    bit si, sq;
    k    = (m == 0) ? 1 : m;
    step = 1 << (12 - k);
    maxd = (1 << k) - 1;
    di = (xi + step / 2) / step;
    si = di > maxd;
    if (si) di = maxd;
    dq = (xq + step / 2) / step;
    sq = dq > maxd;
    if (sq) dq = maxd;
    ei = xi - di * step;
    eq = xq - dq * step;
    if (m == 0) begin
      dq = 0;
      eq = 0;
      sq = 0;
    end
    r.dat = 12'(di + dq * 64);
    r.ei  = 13'(ei);
    r.eq  = 13'(eq);
    r.sat = si || sq;
    return r;
  endfunction

  // One clock: check at the falling edge, update model for the coming edge,
  // return 1 time unit after the rising edge.
  task automatic tick();
    exp_t e;
    bit   adv;
    @(negedge dclk);
    if (hold_chk) begin
      chk("hold_m_valid", m_valid, h_mv);
      chk("hold_data", data, h_data);
      chk("hold_err_i", err_i, h_ei);
      chk("hold_err_q", err_q, h_eq);
    end
    hold_chk = 0;
    chk("sym_count", sym_count, sym_exp);
    chk("sat_count", sat_count, sat_exp);
    adv = en && (!m_valid || m_ready);
    chk("s_ready", s_ready, adv);
    if (rst) begin
      exp_q.delete();
      sym_exp = 0;
      sat_exp = 0;
    end else begin
      if (!adv) begin
        hold_chk = 1;
        h_mv = m_valid;
        h_data = data;
        h_ei = err_i;
        h_eq = err_q;
      end
      if (en && m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_symbol", m_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("data", data, e.dat);
          chk("err_i", err_i, e.ei);
          chk("err_q", err_q, e.eq);
          if (sym_exp < 65535) sym_exp++;
          if (e.sat && sat_exp < 65535) sat_exp++;
        end
      end
      if (s_valid && adv && modi != 3'd7)
        exp_q.push_back(ref_sym(int'(modi), int'(inphase), int'(quadrature)));
    end
    @(posedge dclk);
    #1;
  endtask

  task automatic send(input int m, input int xi, input int xq);
    bit acc;
    acc = 0;
    modi = 3'(m);
    inphase = 12'(xi);
    quadrature = 12'(xq);
    s_valid = 1'b1;
    for (int t = 0; t < 50 && !acc; t++) begin
      #1;
      acc = s_ready;
      tick();
    end
    if (!acc) chk("send_timeout", s_ready, 1'b1);
    s_valid = 1'b0;
  endtask

  task automatic wait_out();
    for (int t = 0; t < 10 && !m_valid; t++) tick();
    chk("wait_out", m_valid, 1'b1);
  endtask

  task automatic drain();
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int t = 0; t < 10 && exp_q.size() != 0; t++) tick();
    chk("drain_left", 32'(exp_q.size()), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic int rand_x();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 4095;
    if (r == 1) return 0;
    return int'($urandom_range(0, 4095));
  endfunction

  // kind 0: mode 4; kind 1: cycle 3,7,5; kind 2: random 0..6
  task automatic stream(input int count, input int kind, input int stall_at);
    int n, c;
    bit acc;
    n = 0;
    c = 0;
    while (n < count && c < 2 * count + 100) begin
      case (kind)
        0: modi = 3'd4;
        1: modi = (n % 3 == 0) ? 3'd3 : ((n % 3 == 1) ? 3'd7 : 3'd5);
        default: modi = 3'($urandom_range(0, 6));
      endcase
      inphase = 12'(rand_x());
      quadrature = 12'(rand_x());
      s_valid = 1'b1;
      m_ready = !(stall_at >= 0 && c >= stall_at && c < stall_at + 3);
      #1;
      acc = s_ready;
      tick();
      if (acc) n++;
      c++;
    end
    chk("stream_count", n, count);
    s_valid = 1'b0;
    m_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b1;
    modi = 3'd0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    inphase = 12'd0;
    quadrature = 12'd0;
    @(posedge dclk);
    #1;
    do_reset();
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_data", data, 12'h000);
    chk("rst_s_ready", s_ready, 1'b1);

    // 16-QAM with explicit latency
    send(2, 1500, 3000);
    chk("t1_lat_c1", m_valid, 1'b0);
    tick();
    chk("t1_lat_c2", m_valid, 1'b1);
    chk("t1_data", data, 12'h0C1);
    chk("t1_err_i", err_i, 13'd476);
    chk("t1_err_q", err_q, 13'h1FB8);
    tick();

    // 4096-QAM saturation and decision threshold
    send(6, 4095, 0);
    wait_out();
    chk("t2_data", data, 12'h03F);
    chk("t2_err_i", err_i, 13'd63);
    chk("t2_err_q", err_q, 13'd0);
    tick();
    chk("t2_sat_count", sat_count, 16'd1);
    send(6, 31, 0);
    wait_out();
    chk("t2_i31", data, 12'h000);
    tick();
    send(6, 32, 0);
    wait_out();
    chk("t2_i32", data, 12'h001);
    chk("t2_i32_err", err_i, 13'h1FE0);
    tick();

    // BPSK threshold, Q ignored
    send(0, 1023, 2048);
    wait_out();
    chk("t3_data0", data, 12'h000);
    chk("t3_err_i0", err_i, 13'd1023);
    chk("t3_err_q0", err_q, 13'd0);
    tick();
    send(0, 1024, 2048);
    wait_out();
    chk("t3_data1", data, 12'h001);
    chk("t3_err_i1", err_i, 13'h1C00);
    chk("t3_err_q1", err_q, 13'd0);
    tick();
    drain();

    // Stalled 256-QAM stream
    do_reset();
    stream(20, 0, 8);
    drain();
    chk("t4_sym_count", sym_count, 16'd20);

    // Mixed modes with idle slots
    do_reset();
    stream(12, 1, -1);
    drain();
    chk("t5_sym_count", sym_count, 16'd8);

    // Long random run to counter saturation
    do_reset();
    stream(65540, 2, 1000);
    drain();
    chk("t6_sym_sat", sym_count, 16'hFFFF);

    // Reset with samples in flight
    send(4, 100, 200);
    m_ready = 1'b0;
    send(4, 300, 400);
    chk("t7_inflight", m_valid, 1'b1);
    do_reset();
    chk("t7_m_valid", m_valid, 1'b0);
    chk("t7_data", data, 12'h000);
    chk("t7_err_i", err_i, 13'd0);
    chk("t7_err_q", err_q, 13'd0);
    chk("t7_sym", sym_count, 16'd0);
    chk("t7_sat", sat_count, 16'd0);
    chk("t7_s_ready", s_ready, 1'b1);
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t7_no_stale", m_valid, 1'b0);
    end

    // Enable low freezes everything
    m_ready = 1'b0;
    send(3, 2222, 1111);
    wait_out();
    en = 1'b0;
    m_ready = 1'b1;
    #1;
    chk("t8_s_ready", s_ready, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk("t8_m_valid", m_valid, 1'b1);
    chk("t8_sym", sym_count, 16'd0);
    en = 1'b1;
    drain();
    chk("t8_sym_after", sym_count, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
